universal_shift_reg_seq: RTL
============================

// Module: universal_shift_reg_seq
// PURPOSE
//   Parametrised universal shift register with a command-driven sequencer.
//   One accepted command performs a parallel load, or a multi-step
//   shift/rotate of cmd_cnt single-bit steps (one step per clock).
//   Completion is reported with a one-cycle done pulse.
//   Sits between a serial link front end and parallel datapath logic.
// PARAMETERS
//   WIDTH  8  register width in bits (>=2)
//   CNT_W  4  width of cmd_cnt; a command may request up to 2**CNT_W-1 steps
// PORTS
//   clk          in   1      single clock, rising edge
//   rst          in   1      synchronous reset, active-high
//   cmd_valid    in   1      command request
//   cmd_ready    out  1      high when IDLE; accept = cmd_valid & cmd_ready
//   cmd_op       in   3      operation code (see BEHAVIOUR)
//   cmd_cnt      in   CNT_W  number of one-bit steps (ignored for LOAD/HOLD)
//   abort        in   1      terminate a running command
//   p_din        in   WIDTH  parallel load data
//   s_right_din  in   1      enters at bit WIDTH-1 on SHR
//   s_left_din   in   1      enters at bit 0 on SHL
//   p_dout       out  WIDTH  register contents
//   s_lsb_dout   out  1      = p_dout[0]
//   s_msb_dout   out  1      = p_dout[WIDTH-1]
//   busy         out  1      high in RUN
//   done         out  1      one-cycle completion pulse
// BEHAVIOUR
//   Reset (rst=1 at an edge): p_dout=0, counter=0, state=IDLE, done=0,
//     busy=0, cmd_ready=1. Reset overrides everything, including a running
//     command; no done is produced.
//   Ops:
//     0 HOLD  1 SHR  2 SHL  3 LOAD  4 ROR  5 ROL  6 ASR (MSB replicated)
//     7 reserved, treated as HOLD.
//   States: IDLE, RUN.
//   IDLE, accept edge:
//     - LOAD: p_dout<=p_din; done=1 in the following cycle; stay IDLE.
//     - HOLD/reserved: no change; done=1 next cycle.
//     - Shift ops with cmd_cnt=0: no change; done=1 next cycle.
//     - Shift ops with cmd_cnt=N>0: latch op, counter<=N, go to RUN.
//       p_dout is unchanged at this edge.
//   RUN, each edge:
//     - Perform one step; s_*_din are sampled at that edge; counter-=1.
//     - On the step where counter==1, go to IDLE and set done=1 for one
//       cycle.
//     - N steps occupy exactly N RUN cycles. cmd_ready and done rise
//       together.
//   cmd_valid while busy is ignored; the command is not queued.
//   abort=1 at an edge in RUN:
//     - No step is performed; go to IDLE; done stays 0.
//     - p_dout keeps its current value.
//     - abort in IDLE has no effect.
//     - If abort and the final step coincide, abort wins.
//   Steps are bit-exact within WIDTH. No carry or overflow output.
//   Counts above WIDTH are legal: SHR/SHL saturate to fill bits, rotates
//   wrap.
//   s_lsb_dout / s_msb_dout are combinational from p_dout: zero latency.
// STRUCTURE
//   Package usr_pkg:
//     - op localparams/typedef (OP_HOLD..OP_ASR)
//     - state encoding (ST_IDLE, ST_RUN)
//   Sub-module usr_step_unit (combinational): computes the next register
//   value from op, current value and serial inputs. Unit-tested standalone.
//   Top holds the FSM, counter, latched op, and the p_dout/done registers.
// TESTING (WIDTH=8, CNT_W=4)
//   1 rst=1 for 2 cycles -> p_dout=0x00, done=0, busy=0, cmd_ready=1.
//     Reset asserted mid-RUN -> same values next edge, no done.
//   2 LOAD p_din=0xB5 -> p_dout=0xB5 after the accept edge; done high
//     exactly 1 cycle; busy never high.
//   3 From 0xB5: SHR cnt=3, s_right_din=1 -> p_dout 0xDA,0xED,0xF6 on
//     successive RUN edges; s_lsb_dout 1,0,1,0; done 1 cycle after the last
//     step.
//   4 From 0xB5: ROL cnt=4 -> 0x5B. ASR cnt=2 -> 0xED.
//     SHL cnt=12, s_left_din=0 -> 0x00.
//   5 From 0xB5: SHL cnt=5, s_left_din=0; abort after 2 steps -> p_dout=0xD4
//     held, no done. cmd_valid while busy is ignored.
//   6 Shift with cnt=0, and op=7 -> p_dout unchanged, done next cycle.
//     Back-to-back commands accepted in the cycle cmd_ready returns.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared op codes, FSM encoding and op classification for the universal shift register.
package usr_pkg;

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_SHR  = 3'd1,
        OP_SHL  = 3'd2,
        OP_LOAD = 3'd3,
        OP_ROR  = 3'd4,
        OP_ROL  = 3'd5,
        OP_ASR  = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic logic is_shift_op(op_e op);
        return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) ||
               (op == OP_ROL) || (op == OP_ASR);
    endfunction

endpackage

// File: rtl/universal_shift_reg_seq_if.sv
// Command / data bundle between the link front end (master) and the shift register (slave).
interface universal_shift_reg_seq_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [CNT_W-1:0] cmd_cnt;
    logic             abort;
    logic [WIDTH-1:0] p_din;
    logic             s_right_din;
    logic             s_left_din;
    logic [WIDTH-1:0] p_dout;
    logic             s_lsb_dout;
    logic             s_msb_dout;
    logic             busy;
    logic             done;

    modport master (
        output cmd_valid, cmd_op, cmd_cnt, abort, p_din, s_right_din, s_left_din,
        input  cmd_ready, p_dout, s_lsb_dout, s_msb_dout, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_cnt, abort, p_din, s_right_din, s_left_din,
        output cmd_ready, p_dout, s_lsb_dout, s_msb_dout, busy, done
    );
endinterface

// File: rtl/usr_step_unit.sv
// Combinational single-step datapath: next register value for one shift/rotate step.
module usr_step_unit
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              i_op,
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_right_din,
    input  logic             i_left_din,
    output logic [WIDTH-1:0] o_val
);
    always_comb begin
        o_val = i_val;
        case (i_op)
            OP_SHR:  o_val = {i_right_din,    i_val[WIDTH-1:1]};
            OP_SHL:  o_val = {i_val[WIDTH-2:0], i_left_din};
            OP_ROR:  o_val = {i_val[0],       i_val[WIDTH-1:1]};
            OP_ROL:  o_val = {i_val[WIDTH-2:0], i_val[WIDTH-1]};
            OP_ASR:  o_val = {i_val[WIDTH-1], i_val[WIDTH-1:1]};
            default: o_val = i_val;
        endcase
    end
endmodule

// File: rtl/universal_shift_reg_seq.sv
// Universal shift register with a command sequencer: LOAD/HOLD complete immediately,
// shift/rotate commands run one step per clock and finish with a one-cycle done pulse.
module universal_shift_reg_seq
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic rst,
    universal_shift_reg_seq_if.slave bus
);
    state_e           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
    op_e              r_op,    w_op_nxt;
    logic [WIDTH-1:0] r_data,  w_data_nxt;
    logic             r_done,  w_done_nxt;
    logic [WIDTH-1:0] w_step;
    logic             w_accept;
    op_e              w_cmd_op;

    assign w_cmd_op = op_e'(bus.cmd_op);
    assign w_accept = bus.cmd_valid && (r_state == ST_IDLE);

    usr_step_unit #(.WIDTH(WIDTH)) u_step (
        .i_op        (r_op),
        .i_val       (r_data),
        .i_right_din (bus.s_right_din),
        .i_left_din  (bus.s_left_din),
        .o_val       (w_step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= OP_HOLD;
            r_data  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
            r_data  <= w_data_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        w_data_nxt  = r_data;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_cmd_op == OP_LOAD) begin
                        w_data_nxt = bus.p_din;
                        w_done_nxt = 1'b1;
                    end else if (is_shift_op(w_cmd_op) && (bus.cmd_cnt != '0)) begin
                        w_op_nxt    = w_cmd_op;
                        w_cnt_nxt   = bus.cmd_cnt;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // Abort takes priority over the step, including the final one.
                if (bus.abort) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_data_nxt = w_step;
                    w_cnt_nxt  = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.cmd_ready  = (r_state == ST_IDLE);
    assign bus.busy       = (r_state == ST_RUN);
    assign bus.done       = r_done;
    assign bus.p_dout     = r_data;
    assign bus.s_lsb_dout = r_data[0];
    assign bus.s_msb_dout = r_data[WIDTH-1];

endmodule
